// File: rtl/pu_col_feeder.sv
// Column feeder: streams 5-row bands of pixels into the PU G-buffer
// and paces one window cycle per new column.
module pu_col_feeder #(
    parameter int data_width  = 16,
    parameter int img_w       = 28,
    parameter int img_h       = 28,
    parameter int address_num = 3
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   frame_start,
    input  logic [data_width-1:0]  pix_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic                   wr_ctrl_g,
    output logic [address_num-1:0] adrs_out,
    output logic [data_width-1:0]  g_data,
    output logic                   pu_start,
    output logic                   round,
    output logic                   neightor_in_flag,
    input  logic                   win_ack,
    output logic                   frame_done
);

    localparam int CW = $clog2(img_w);
    localparam int BW = $clog2(img_h);
    localparam logic [CW-1:0] COL_LAST  = CW'(img_w - 1);
    localparam logic [BW-1:0] BAND_LAST = BW'(img_h - 5);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        NEXT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   col_cnt, col_nx;
    logic [BW-1:0]   band_cnt, band_nx;
    logic [2:0]      row_cnt, row_nx;
    logic            round_q, round_nx;
    logic            pu_q, pu_nx;
    logic            ready_c, wr_c, done_c;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            col_cnt  <= '0;
            band_cnt <= '0;
            row_cnt  <= '0;
            round_q  <= 1'b0;
            pu_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            col_cnt  <= col_nx;
            band_cnt <= band_nx;
            row_cnt  <= row_nx;
            round_q  <= round_nx;
            pu_q     <= pu_nx;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col_cnt;
        band_nx  = band_cnt;
        row_nx   = row_cnt;
        round_nx = round_q;
        pu_nx    = 1'b0;
        ready_c  = 1'b0;
        wr_c     = 1'b0;
        done_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nx = LOAD;
                    col_nx   = '0;
                    band_nx  = '0;
                    row_nx   = '0;
                    round_nx = 1'b1;
                end
            end
            LOAD: begin
                ready_c = 1'b1;
                if (pix_valid) begin
                    wr_c = 1'b1;
                    if (row_cnt == 3'd4) begin
                        row_nx = '0;
                        // the first four columns of a band only prefill
                        if (round_q && col_cnt < CW'(4)) begin
                            col_nx = col_cnt + 1'b1;
                        end else begin
                            pu_nx    = 1'b1;
                            state_nx = WAIT_ACK;
                        end
                    end else begin
                        row_nx = row_cnt + 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (win_ack) state_nx = NEXT;
            end
            NEXT: begin
                if (col_cnt != COL_LAST) begin
                    col_nx   = col_cnt + 1'b1;
                    round_nx = 1'b0;
                    state_nx = LOAD;
                end else if (band_cnt != BAND_LAST) begin
                    band_nx  = band_cnt + 1'b1;
                    col_nx   = '0;
                    round_nx = 1'b1;
                    state_nx = LOAD;
                end else begin
                    done_c   = 1'b1;
                    round_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs are forced low while reset is asserted, whatever the state
    assign pix_ready  = nrst & ready_c;
    assign wr_ctrl_g  = nrst & wr_c;
    assign adrs_out   = wr_ctrl_g ? address_num'(row_cnt) : '0;
    assign g_data     = wr_ctrl_g ? pix_data : '0;
    assign pu_start   = nrst & pu_q;
    assign round      = nrst & round_q;
    assign frame_done = nrst & done_c;
    assign neightor_in_flag = nrst & (state == LOAD) & round_q
                            & (col_cnt < CW'(4));

endmodule

// File: tb/tb_pu_col_feeder.sv
// Bench for pu_col_feeder on an 8x6 image: scoreboard of G-buffer
// writes and window pulses checked by an independent monitor.
module tb_pu_col_feeder;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AN = 3;

    logic          clk = 0;
    logic          nrst = 0;
    logic          frame_start = 0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_valid = 0;
    logic          pix_ready;
    logic          wr_ctrl_g;
    logic [AN-1:0] adrs_out;
    logic [DW-1:0] g_data;
    logic          pu_start;
    logic          round;
    logic          neightor_in_flag;
    logic          win_ack = 0;
    logic          frame_done;

    pu_col_feeder #(
        .data_width (DW),
        .img_w      (W),
        .img_h      (H),
        .address_num(AN)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .frame_start     (frame_start),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .wr_ctrl_g       (wr_ctrl_g),
        .adrs_out        (adrs_out),
        .g_data          (g_data),
        .pu_start        (pu_start),
        .round           (round),
        .neightor_in_flag(neightor_in_flag),
        .win_ack         (win_ack),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    a;
        logic [DW-1:0] d;
        logic          nif;
    } px_t;

    typedef struct {
        logic r;
        int   n;
    } pu_t;

    px_t exp_px[$];
    pu_t exp_pu[$];

    int total = 0;
    int bad = 0;
    int pix_seen = 0;
    int pu_seen = 0;
    int fd_cnt = 0;
    int ack_dly = 2;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic miss(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got none expected event", nm);
    endtask

    // monitor: pops scoreboard entries whenever the DUT acts
    initial begin : monitor
        px_t e;
        pu_t p;
        bit  waiting;
        logic wround;
        waiting = 0;
        wround = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                waiting = 0;
            end else begin
                if (waiting) begin
                    chk("wait_ready", 32'(pix_ready), 0);
                    chk("wait_wr", 32'(wr_ctrl_g), 0);
                    chk("wait_round", 32'(round), 32'(wround));
                    if (win_ack) waiting = 0;
                end
                if (wr_ctrl_g) begin
                    if (exp_px.size() == 0) begin
                        miss("px_extra");
                    end else begin
                        e = exp_px.pop_front();
                        chk("adrs", 32'(adrs_out), 32'(e.a));
                        chk("gdata", 32'(g_data), 32'(e.d));
                        chk("nif", 32'(neightor_in_flag), 32'(e.nif));
                    end
                    pix_seen++;
                end
                if (pu_start) begin
                    if (exp_pu.size() == 0) begin
                        miss("pu_extra");
                    end else begin
                        p = exp_pu.pop_front();
                        chk("pu_round", 32'(round), 32'(p.r));
                        chk("pu_pix", 32'(pix_seen), 32'(p.n));
                    end
                    pu_seen++;
                    waiting = 1;
                    wround = round;
                end
                if (frame_done) begin
                    chk("fd_pix", 32'(pix_seen), 80);
                    chk("fd_win", 32'(pu_seen), 8);
                    chk("fd_pu_left", 32'(exp_pu.size()), 0);
                    fd_cnt++;
                end
            end
        end
    end

    initial begin : responder
        forever begin
            @(negedge clk);
            if (nrst && pu_start) begin
                repeat (ack_dly) @(posedge clk);
                #1 win_ack = 1;
                @(posedge clk);
                #1 win_ack = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic zeros(input string nm);
        chk({nm, "_ready"}, 32'(pix_ready), 0);
        chk({nm, "_wr"}, 32'(wr_ctrl_g), 0);
        chk({nm, "_pu"}, 32'(pu_start), 0);
        chk({nm, "_fd"}, 32'(frame_done), 0);
        chk({nm, "_nif"}, 32'(neightor_in_flag), 0);
        chk({nm, "_round"}, 32'(round), 0);
        chk({nm, "_adrs"}, 32'(adrs_out), 0);
        chk({nm, "_gdata"}, 32'(g_data), 0);
    endtask

    task automatic start_frame();
        pix_seen = 0;
        pu_seen = 0;
        for (int b = 0; b < 2; b++) begin
            exp_pu.push_back('{r: 1'b1, n: 40 * b + 25});
            exp_pu.push_back('{r: 1'b0, n: 40 * b + 30});
            exp_pu.push_back('{r: 1'b0, n: 40 * b + 35});
            exp_pu.push_back('{r: 1'b0, n: 40 * b + 40});
        end
        @(posedge clk);
        #1 frame_start = 1;
        @(posedge clk);
        #1 frame_start = 0;
        @(negedge clk);
        chk("start_round", 32'(round), 1);
        chk("start_nif", 32'(neightor_in_flag), 1);
        chk("start_ready", 32'(pix_ready), 1);
    endtask

    task automatic feed(input int n, input bit rnd, input bit spur);
        int  k = 0;
        int  pushed = -1;
        int  cyc = 0;
        bit  sp = 0;
        while (k < n && cyc < 5000) begin
            @(posedge clk);
            #1;
            if (sp) begin
                frame_start = 0;
                win_ack = 0;
                sp = 0;
            end
            if (spur && (k == 7 || k == 50) && pushed != k) begin
                frame_start = 1;
                win_ack = 1;
                sp = 1;
            end
            pix_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_data = DW'(16'h1200 + k * 37);
            if (pushed != k) begin
                exp_px.push_back('{a: 3'(k % 5), d: pix_data,
                                   nif: (k % 40) < 20});
                pushed = k;
            end
            @(negedge clk);
            if (pix_valid && pix_ready) k++;
            cyc++;
        end
        if (k < n) miss("feed_timeout");
        @(posedge clk);
        #1 pix_valid = 0;
        if (sp) begin
            frame_start = 0;
            win_ack = 0;
        end
    endtask

    task automatic wait_fd();
        int f0 = fd_cnt;
        int cyc = 0;
        while (fd_cnt == f0 && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        if (fd_cnt == f0) miss("frame_done_timeout");
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input bit rnd, input int dly, input bit spur);
        ack_dly = dly;
        start_frame();
        feed(80, rnd, spur);
        wait_fd();
    endtask

    initial begin : stim
        repeat (2) @(posedge clk);
        pix_valid = 1;
        @(negedge clk);
        zeros("rst");
        @(posedge clk);
        #1 nrst = 1;
        @(negedge clk);
        zeros("post_rst");
        pix_valid = 0;

        run(0, 2, 0);
        run(1, 2, 0);
        run(0, 50, 0);

        ack_dly = 2;
        start_frame();
        feed(13, 0, 0);
        pix_valid = 1;
        pix_data = 16'hBEEF;
        nrst = 0;
        @(negedge clk);
        zeros("mid_rst");
        @(posedge clk);
        #1 nrst = 1;
        @(negedge clk);
        zeros("mid_post");
        chk("mid_pix", 32'(pix_seen), 13);
        pix_valid = 0;
        exp_px.delete();
        exp_pu.delete();

        run(0, 2, 1);

        chk("frames", 32'(fd_cnt), 4);
        chk("px_left", 32'(exp_px.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
